// File: rtl/uart_cmd_master.sv
// Host-side UART command initiator: serialises one command frame to a byte
// transmitter, then waits for a single response byte or a timeout.
module uart_cmd_master #(
   parameter int Data_width     = 8,
   parameter int Address_width  = 4,
   parameter int TIMEOUT_WIDTH  = 16,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_type,
   input  logic [Address_width-1:0] cmd_addr,
   input  logic [Data_width-1:0]    cmd_wdata,
   input  logic [Data_width-1:0]    cmd_op_a,
   input  logic [Data_width-1:0]    cmd_op_b,
   input  logic [3:0]               cmd_fun,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic [Data_width-1:0]    rsp_data,
   output logic                     rsp_valid,
   output logic                     rsp_timeout,
   output logic                     busy
);

   localparam logic [1:0] RF_WR   = 2'b00;
   localparam logic [1:0] RF_RD   = 2'b01;
   localparam logic [1:0] ALU_OP  = 2'b10;
   localparam logic [1:0] ALU_NOP = 2'b11;
   localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_t;

   typedef struct packed {
      logic [1:0]               typ;
      logic [Address_width-1:0] addr;
      logic [Data_width-1:0]    wdata;
      logic [Data_width-1:0]    op_a;
      logic [Data_width-1:0]    op_b;
      logic [3:0]               fun;
   } cmd_t;

   state_t                   state_q, state_d;
   cmd_t                     cmd_q;
   logic [1:0]               idx_q;
   logic [TIMEOUT_WIDTH-1:0] cnt_q;
   logic [7:0]               frame_byte;
   logic [1:0]               last_idx;
   logic                     accept, tx_fire, last_fire, rsp_hit, tmo_hit;

   // Frame byte selection from the latched command; bytes past the end read 0.
   always_comb begin
      frame_byte = 8'h00;
      last_idx   = 2'd1;
      unique case (cmd_q.typ)
         RF_WR: begin
            last_idx = 2'd2;
            case (idx_q)
               2'd0:    frame_byte = 8'hAA;
               2'd1:    frame_byte = 8'(cmd_q.addr);
               2'd2:    frame_byte = 8'(cmd_q.wdata);
               default: frame_byte = 8'h00;
            endcase
         end
         RF_RD: begin
            case (idx_q)
               2'd0:    frame_byte = 8'hBB;
               2'd1:    frame_byte = 8'(cmd_q.addr);
               default: frame_byte = 8'h00;
            endcase
         end
         ALU_OP: begin
            last_idx = 2'd3;
            case (idx_q)
               2'd0:    frame_byte = 8'hCC;
               2'd1:    frame_byte = 8'(cmd_q.op_a);
               2'd2:    frame_byte = 8'(cmd_q.op_b);
               default: frame_byte = 8'(cmd_q.fun);
            endcase
         end
         ALU_NOP: begin
            case (idx_q)
               2'd0:    frame_byte = 8'hDD;
               2'd1:    frame_byte = 8'(cmd_q.fun);
               default: frame_byte = 8'h00;
            endcase
         end
         default: frame_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cmd_ready = (state_q == IDLE);
      busy      = (state_q != IDLE);
      tx_valid  = (state_q == SEND);
      tx_data   = 8'h00;
      accept    = 1'b0;
      tx_fire   = 1'b0;
      last_fire = 1'b0;
      rsp_hit   = 1'b0;
      tmo_hit   = 1'b0;
      unique case (state_q)
         IDLE: begin
            accept = cmd_valid;
            if (cmd_valid) state_d = SEND;
         end
         SEND: begin
            tx_data   = frame_byte;
            tx_fire   = tx_ready;
            last_fire = tx_ready && (idx_q == last_idx);
            if (last_fire) state_d = (cmd_q.typ == RF_WR) ? IDLE : WAIT_RSP;
         end
         WAIT_RSP: begin
            // A response arriving on the terminal-count cycle beats the timeout.
            rsp_hit = rx_valid;
            tmo_hit = !rx_valid && (cnt_q == TMO_LAST);
            if (rsp_hit || tmo_hit) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         rsp_data    <= '0;
         rsp_valid   <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid   <= rsp_hit;
         rsp_timeout <= tmo_hit;
         if (accept) begin
            cmd_q <= '{typ: cmd_type, addr: cmd_addr, wdata: cmd_wdata,
                       op_a: cmd_op_a, op_b: cmd_op_b, fun: cmd_fun};
            idx_q <= '0;
         end else if (tx_fire) begin
            idx_q <= idx_q + 2'd1;
         end
         // Counter runs only while waiting, so it is zero on entry.
         cnt_q <= (state_q == WAIT_RSP) ? cnt_q + 1'b1 : '0;
         if (rsp_hit) rsp_data <= Data_width'(rx_data);
      end
   end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Randomised bench for uart_cmd_master: frames, response/timeout timing,
// stray rx bytes and mid-frame reset checked against a frame-table model.
module tb_uart_cmd_master;
   localparam int T = 24;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       cmd_valid = 1'b0, cmd_ready;
   logic [1:0] cmd_type = '0;
   logic [3:0] cmd_addr = '0, cmd_fun = '0;
   logic [7:0] cmd_wdata = '0, cmd_op_a = '0, cmd_op_b = '0;
   logic [7:0] tx_data, rx_data = '0, rsp_data;
   logic       tx_valid, tx_ready = 1'b0, rx_valid = 1'b0;
   logic       rsp_valid, rsp_timeout, busy;

   int         n_tests = 0, n_fail = 0;
   logic [7:0] last_rsp = 8'h00;

   uart_cmd_master #(.TIMEOUT_CYCLES(T)) dut (
      .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b), .cmd_fun(cmd_fun),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rsp_data(rsp_data),
      .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_tx_valid"}, tx_valid, 0);
      chk({tag, "_tx_data"}, tx_data, 0);
      chk({tag, "_rsp_data"}, rsp_data, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
   endtask

   task automatic scramble_cmd();
      cmd_type  = 2'($urandom);
      cmd_addr  = 4'($urandom);
      cmd_wdata = 8'($urandom);
      cmd_op_a  = 8'($urandom);
      cmd_op_b  = 8'($urandom);
      cmd_fun   = 4'($urandom);
   endtask

   // Idle cycles with stray rx bytes that must be ignored.
   task automatic idle(input int k);
      repeat (k) begin
         rx_valid = 1'($urandom_range(0, 1));
         rx_data  = 8'h55;
         tx_ready = 1'($urandom);
         @(negedge CLK);
         chk("idle_busy", busy, 0);
         chk("idle_tx_valid", tx_valid, 0);
         chk("idle_rsp_valid", rsp_valid, 0);
         chk("idle_rsp_data", rsp_data, last_rsp);
      end
      rx_valid = 1'b0;
   endtask

   // mode: 0 tx_ready always, 1 ready one cycle in three, 2 random.
   // d: cycle in the wait phase on which the response byte arrives; d >= T means none.
   task automatic do_cmd(input logic [1:0] typ, input logic [3:0] addr, input logic [7:0] wd,
                         input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun,
                         input int mode, input int d, input logic [7:0] rbyte, input bit stray);
      logic [7:0] fr[4];
      int n, i, c;
      bit rdy;
      case (typ)
         2'b00:   begin fr = '{8'hAA, {4'h0, addr}, wd, 8'h00}; n = 3; end
         2'b01:   begin fr = '{8'hBB, {4'h0, addr}, 8'h00, 8'h00}; n = 2; end
         2'b10:   begin fr = '{8'hCC, a, b, {4'h0, fun}}; n = 4; end
         default: begin fr = '{8'hDD, {4'h0, fun}, 8'h00, 8'h00}; n = 2; end
      endcase
      cmd_type = typ; cmd_addr = addr; cmd_wdata = wd;
      cmd_op_a = a; cmd_op_b = b; cmd_fun = fun;
      cmd_valid = 1'b1;
      rx_valid  = 1'b0;
      #1;
      chk("accept_cmd_ready", cmd_ready, 1);
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
      scramble_cmd();
      i = 0; c = 0;
      while (i < n && c < 200) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (c % 3 == 2);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         tx_ready = rdy;
         rx_valid = stray && ($urandom_range(0, 1) == 0);
         rx_data  = 8'h55;
         @(negedge CLK);
         chk("send_tx_valid", tx_valid, 1);
         chk("send_tx_data", tx_data, fr[i]);
         chk("send_cmd_ready", cmd_ready, 0);
         chk("send_busy", busy, 1);
         chk("send_rsp_valid", rsp_valid, 0);
         chk("send_rsp_timeout", rsp_timeout, 0);
         chk("send_rsp_data", rsp_data, last_rsp);
         @(posedge CLK); #1;
         if (rdy) i++;
         c++;
      end
      chk("send_bound", i, n);
      if (mode == 0) chk("frame_cycles", c, n);
      rx_valid = 1'b0;
      tx_ready = 1'($urandom);
      if (typ == 2'b00) begin
         @(negedge CLK);
         chk("wr_done_cmd_ready", cmd_ready, 1);
         chk("wr_done_busy", busy, 0);
         chk("wr_done_tx_valid", tx_valid, 0);
         chk("wr_done_tx_data", tx_data, 0);
         chk("wr_done_rsp_valid", rsp_valid, 0);
         chk("wr_done_rsp_timeout", rsp_timeout, 0);
         chk("wr_done_rsp_data", rsp_data, last_rsp);
      end else begin
         for (int j = 0; j < T && j <= d; j++) begin
            rx_valid = (j == d);
            rx_data  = rbyte;
            @(negedge CLK);
            chk("wait_busy", busy, 1);
            chk("wait_tx_valid", tx_valid, 0);
            chk("wait_rsp_valid", rsp_valid, 0);
            chk("wait_rsp_timeout", rsp_timeout, 0);
            @(posedge CLK); #1;
         end
         rx_valid = 1'b0;
         if (d < T) last_rsp = rbyte;
         @(negedge CLK);
         chk("end_rsp_valid", rsp_valid, (d < T) ? 1 : 0);
         chk("end_rsp_timeout", rsp_timeout, (d < T) ? 0 : 1);
         chk("end_rsp_data", rsp_data, last_rsp);
         chk("end_cmd_ready", cmd_ready, 1);
         chk("end_busy", busy, 0);
      end
   endtask

   // ALU_OP cut off by reset once two bytes have been taken.
   task automatic reset_mid_frame();
      cmd_type = 2'b10; cmd_op_a = 8'h12; cmd_op_b = 8'h34; cmd_fun = 4'h9;
      cmd_valid = 1'b1;
      tx_ready  = 1'b1;
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      chk("rst_pre_tx_valid", tx_valid, 1);
      chk("rst_pre_tx_data", tx_data, 8'h34);
      #1 RST = 1'b1;
      #1;
      chk_reset_vals("rst_mid");
      last_rsp = 8'h00;
      @(negedge CLK);
      RST = 1'b0;
      tx_ready = 1'b0;
   endtask

   initial begin
      #1 RST = 1'b1;
      repeat (2) @(negedge CLK);
      chk_reset_vals("reset");
      RST = 1'b0;
      @(posedge CLK); #1;

      do_cmd(2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, 0, 8'h00, 0);
      do_cmd(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 0, 20, 8'h81, 0);
      do_cmd(2'b10, 4'h0, 8'h00, 8'h0A, 8'h05, 4'h0, 1, 3, 8'h0F, 0);
      do_cmd(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3, 0, T + 5, 8'h00, 0);
      do_cmd(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3, 0, T - 1, 8'h77, 0);
      idle(4);
      do_cmd(2'b01, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0, 2, 0, 8'h3E, 1);
      reset_mid_frame();
      idle(2);
      do_cmd(2'b10, 4'h0, 8'h00, 8'hA5, 8'h5A, 4'hC, 0, 5, 8'hE1, 0);

      for (int k = 0; k < 40; k++) begin
         do_cmd(2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom), 4'($urandom), $urandom_range(0, 2), $urandom_range(0, T + 4),
                8'($urandom), 1'($urandom_range(0, 1)));
         idle($urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
